int_arbiter: RTL and testbench
==============================

INT_ARBITER -- requirements
Module: int_arbiter

Interface
REQ-001 The block SHALL have parameter EDGE_MASK, default 16'h0000, meaning a per-source sense select where bit i = 1 is rising-edge and bit i = 0 is level-high.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port irq_src, input, 16 bits: raw request lines, already synchronous to clk.
REQ-005 The block SHALL have port en_we, input, 1 bit: write strobe for the enable register.
REQ-006 The block SHALL have port en_wdata, input, 16 bits: new enable value, where bit i = 1 means source i is enabled.
REQ-007 The block SHALL have port irq_ack, input, 1 bit: single-cycle acknowledge from the CPU.
REQ-008 The block SHALL have port irq, output, 1 bit: interrupt request to the CPU.
REQ-009 The block SHALL have port irq_id, output, 4 bits: index of the granted source, which feeds the 4-to-16 clear/ack decoder.
REQ-010 The block SHALL have port pending, output, 16 bits: pending-status register.
REQ-011 The block SHALL have port enable, output, 16 bits: enable-register readback.

Function
REQ-012 The pending bit of each source SHALL be set as follows:
- Edge source: set on a 0->1 transition of irq_src[i], detected against a one-cycle registered copy.
- Level source: pending[i] is set whenever irq_src[i] = 1.
REQ-013 Eligible SHALL be defined as pending & enable; disabled sources SHALL still accumulate pending.
REQ-014 The FSM SHALL have states IDLE and ASSERT, with these transitions:
- IDLE -> ASSERT when eligible != 0.
- ASSERT -> IDLE on irq_ack.
- No other transitions exist.
REQ-015 On IDLE->ASSERT the block SHALL register the selected index into irq_id, so that eligible seen at edge N gives irq = 1 and a valid irq_id after edge N+1 (1-cycle latency).
REQ-016 irq SHALL be 1 exactly in ASSERT.
REQ-017 irq_id SHALL stay frozen throughout ASSERT, even if eligible changes or enable[irq_id] is cleared; there is no retraction.
REQ-018 irq_ack in ASSERT SHALL clear pending[irq_id] at that edge and return the FSM to IDLE; irq = 0 for at least one cycle before any re-assert.
REQ-019 A set and a clear of the same pending bit in the same cycle SHALL resolve as set wins, so no edge is lost.
REQ-020 A level source still high after ack SHALL re-pend on the next cycle.
REQ-021 irq_ack in IDLE SHALL be ignored, with no state or register change.
REQ-022 en_we SHALL load enable at the edge and take effect for selection from the next cycle.
REQ-023 Selection SHALL be fixed priority, lowest index wins, unless IRQ_RR_EN is defined (see Configuration).
REQ-024 irq_id SHALL be 0 in IDLE.

Reset
REQ-025 While rst_n = 0, the block SHALL asynchronously force the following values:
- state = IDLE.
- irq = 0.
- irq_id = 4'h0.
- pending = 16'h0000.
- enable = 16'h0000.
- Edge-history register = 16'h0000.
- Round-robin pointer = 4'hF.
REQ-026 Reset asserted in ASSERT SHALL abandon the grant; after release no ack is expected.
REQ-027 A source held high through reset release SHALL NOT register as an edge; it is treated as a level source if configured as level.

Configuration
REQ-028 The macro IRQ_RR_EN SHALL select the arbitration policy:
- Defined: round-robin. A last-grant pointer updates to irq_id on each ack, and the search starts at pointer+1 mod 16, wrapping 15->0.
- Undefined: fixed priority, with the pointer logic absent.

Structure
REQ-029 Package int_pkg SHALL hold NUM_SRC = 16, ID_W = 4, and the FSM state type with the encodings IDLE = 1'b0 and ASSERT = 1'b1.
REQ-030 Sub-module prio_enc16 SHALL map a 16-bit request plus a 4-bit start index to a 4-bit index plus a valid flag.
REQ-031 In fixed-priority builds, the start index of prio_enc16 SHALL be tied to 0.

Verification
REQ-032 Reset, then enable = 16'hFFFF and a pulse on edge source 5 -> irq = 1 and irq_id = 5 one cycle after pending[5] is set; after ack, pending[5] = 0 and irq = 0.
REQ-033 Pend sources 3 and 9 together under fixed priority -> grant 3, ack, one idle cycle, then grant 9.
REQ-034 With IRQ_RR_EN, hold sources 2 and 14 pending continuously at level -> grants alternate 2, 14, 2, 14.
REQ-035 With enable = 16'h0000 and source 7 pulsed -> pending[7] = 1 and irq = 0; then write enable = 16'h0080 -> irq = 1 and irq_id = 7.
REQ-036 Send a second edge on source 4 in the same cycle as the ack of grant 4 -> pending[4] stays 1 and 4 is re-granted after one idle cycle.
REQ-037 Assert rst_n = 0 mid-ASSERT -> irq = 0 and pending = 0 immediately, without waiting for clk; irq_ack pulsed in IDLE -> no change.

Source files
------------

// File: rtl/int_pkg.sv
// Shared constants and FSM state type for the interrupt arbiter.
package int_pkg;
    localparam int NUM_SRC = 16;
    localparam int ID_W    = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        ASSERT = 1'b1
    } state_t;
endpackage

// File: rtl/int_arbiter_prio_enc16.sv
// Circular priority encoder: returns the first set request at or after start,
// wrapping 15->0.
module prio_enc16
    import int_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    logic [ID_W-1:0] cand [NUM_SRC];

    // 4-bit addition wraps naturally, giving the modulo-16 search order.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            assign cand[gi] = start + ID_W'(gi);
        end
    endgenerate

    // Scan from the far end so the candidate nearest to start is kept last.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                idx   = cand[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// 16-source interrupt arbiter with per-source edge/level sense and enable mask.
// Define IRQ_RR_EN for round-robin arbitration; otherwise lowest index wins.
module int_arbiter
    import int_pkg::*;
#(
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               en_we,
    input  logic [NUM_SRC-1:0] en_wdata,
    input  logic               irq_ack,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] enable
);

    state_t             state_reg;
    logic               irq_reg;
    logic [ID_W-1:0]    id_reg;
    logic [NUM_SRC-1:0] pending_reg;
    logic [NUM_SRC-1:0] enable_reg;
    logic [NUM_SRC-1:0] hist_reg;
    // Low for the first edge after reset so a line already high is not an edge.
    logic               armed_reg;

    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] clear_vec;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] eligible;
    logic [ID_W-1:0]    start_idx;
    logic [ID_W-1:0]    sel_idx;
    logic               sel_valid;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sense
            if (EDGE_MASK[gi]) begin : g_edge
                assign set_vec[gi] = armed_reg & irq_src[gi] & ~hist_reg[gi];
            end else begin : g_level
                assign set_vec[gi] = irq_src[gi];
            end
        end
    endgenerate

    assign clear_vec    = (state_reg == ASSERT && irq_ack)
                        ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << id_reg) : '0;
    // Set is applied after clear so a new request on the acked source survives.
    assign pending_next = (pending_reg & ~clear_vec) | set_vec;
    assign eligible     = pending_reg & enable_reg;

`ifdef IRQ_RR_EN
    logic [ID_W-1:0] ptr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 4'hF;
        end else if (state_reg == ASSERT && irq_ack) begin
            ptr_reg <= id_reg;
        end
    end

    assign start_idx = ptr_reg + 1'b1;
`else
    assign start_idx = '0;
`endif

    prio_enc16 u_prio (
        .req   (eligible),
        .start (start_idx),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            irq_reg     <= 1'b0;
            id_reg      <= '0;
            pending_reg <= '0;
            enable_reg  <= '0;
            hist_reg    <= '0;
            armed_reg   <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            hist_reg    <= irq_src;
            armed_reg   <= 1'b1;
            if (en_we) begin
                enable_reg <= en_wdata;
            end
            case (state_reg)
                IDLE: begin
                    if (sel_valid) begin
                        state_reg <= ASSERT;
                        irq_reg   <= 1'b1;
                        id_reg    <= sel_idx;
                    end
                end
                ASSERT: begin
                    if (irq_ack) begin
                        state_reg <= IDLE;
                        irq_reg   <= 1'b0;
                        id_reg    <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    irq_reg   <= 1'b0;
                    id_reg    <= '0;
                end
            endcase
        end
    end

    assign irq     = irq_reg;
    assign irq_id  = id_reg;
    assign pending = pending_reg;
    assign enable  = enable_reg;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed scenarios plus randomized
// traffic against a behavioural model.
module tb_int_arbiter;

    localparam logic [15:0] EMASK = 16'h02F0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] irq_src = '0;
    logic        en_we = 1'b0;
    logic [15:0] en_wdata = '0;
    logic        irq_ack = 1'b0;
    logic        irq;
    logic [3:0]  irq_id;
    logic [15:0] pending;
    logic [15:0] enable;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit m_pend [16];
    bit m_en   [16];
    bit m_prev [16];
    bit m_fresh;
    bit m_busy;
    int m_id;
    int m_last;

    int_arbiter #(.EDGE_MASK(EMASK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_src  (irq_src),
        .en_we    (en_we),
        .en_wdata (en_wdata),
        .irq_ack  (irq_ack),
        .irq      (irq),
        .irq_id   (irq_id),
        .pending  (pending),
        .enable   (enable)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack16(input bit a [16]);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pend[i] = 0;
            m_en[i]   = 0;
            m_prev[i] = 0;
        end
        m_fresh = 1;
        m_busy  = 0;
        m_id    = 0;
        m_last  = 15;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_step();
        bit np [16];
        int start;
        int found;
        np = m_pend;
        if (m_busy && irq_ack) np[m_id] = 0;
        for (int i = 0; i < 16; i++) begin
            if (EMASK[i]) begin
                if (irq_src[i] && !m_prev[i] && !m_fresh) np[i] = 1;
            end else if (irq_src[i]) begin
                np[i] = 1;
            end
        end
        if (!m_busy) begin
`ifdef IRQ_RR_EN
            start = (m_last + 1) % 16;
`else
            start = 0;
`endif
            found = -1;
            for (int k = 0; k < 16; k++) begin
                int s;
                s = (start + k) % 16;
                if (found < 0 && m_pend[s] && m_en[s]) found = s;
            end
            if (found >= 0) begin
                m_busy = 1;
                m_id   = found;
            end
        end else if (irq_ack) begin
            m_last = m_id;
            m_busy = 0;
            m_id   = 0;
        end
        for (int i = 0; i < 16; i++) begin
            m_prev[i] = irq_src[i];
            if (en_we) m_en[i] = en_wdata[i];
        end
        m_pend  = np;
        m_fresh = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".irq"}, 32'(irq), 32'(m_busy));
        chk({tag, ".id"}, 32'(irq_id), 32'(m_id));
        chk({tag, ".pend"}, 32'(pending), 32'(pack16(m_pend)));
        chk({tag, ".en"}, 32'(enable), 32'(pack16(m_en)));
        $display("[%0t] %-10s src=%h ack=%b we=%b | irq=%b id=%0d pend=%h en=%h",
                 $time, tag, irq_src, irq_ack, en_we, irq, irq_id, pending, enable);
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Reset is applied between clock edges so its effect is checked before any clock.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ".irq0"}, 32'(irq), 32'd0);
        chk({tag, ".pend0"}, 32'(pending), 32'd0);
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic quiet_inputs();
        irq_src  = '0;
        en_we    = 1'b0;
        irq_ack  = 1'b0;
    endtask

    initial begin
        int exp_id;

        model_reset();
        quiet_inputs();
        #12;
        compare_all("reset");
        rst_n = 1'b1;

        // Single edge source 5
        en_we = 1'b1; en_wdata = 16'hFFFF;
        step("s5.en");
        en_we = 1'b0; irq_src[5] = 1'b1;
        step("s5.rise");
        chk("s5.pend", 32'(pending[5]), 32'd1);
        irq_src[5] = 1'b0;
        step("s5.grant");
        chk("s5.irq", 32'(irq), 32'd1);
        chk("s5.id", 32'(irq_id), 32'd5);
        irq_ack = 1'b1;
        step("s5.ack");
        chk("s5.clr", 32'(pending[5]), 32'd0);
        chk("s5.irqlo", 32'(irq), 32'd0);
        irq_ack = 1'b0;

        // Sources 3 (level) and 9 (edge) together
        async_reset("r33");
        en_we = 1'b1; en_wdata = 16'hFFFF;
        step("p39.en");
        en_we = 1'b0; irq_src[3] = 1'b1; irq_src[9] = 1'b1;
        step("p39.set");
        irq_src = '0;
        step("p39.g3");
        chk("p39.id3", 32'(irq_id), 32'd3);
        irq_ack = 1'b1;
        step("p39.ack3");
        chk("p39.gap", 32'(irq), 32'd0);
        irq_ack = 1'b0;
        step("p39.g9");
        chk("p39.id9", 32'(irq_id), 32'd9);
        irq_ack = 1'b1;
        step("p39.ack9");
        irq_ack = 1'b0;

        // Level sources 2 and 14 held continuously
        async_reset("r34");
        en_we = 1'b1; en_wdata = 16'hFFFF;
        step("rr.en");
        en_we = 1'b0; irq_src[2] = 1'b1; irq_src[14] = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int w = 0; w < 6 && !irq; w++) step("rr.wait");
            chk("rr.irq", 32'(irq), 32'd1);
`ifdef IRQ_RR_EN
            exp_id = (g % 2 == 0) ? 2 : 14;
`else
            exp_id = 2;
`endif
            chk("rr.id", 32'(irq_id), 32'(exp_id));
            irq_ack = 1'b1;
            step("rr.ack");
            irq_ack = 1'b0;
        end
        quiet_inputs();

        // Disabled source accumulates pending
        async_reset("r35");
        en_we = 1'b1; en_wdata = 16'h0000;
        step("dis.en0");
        en_we = 1'b0; irq_src[7] = 1'b1;
        step("dis.rise");
        irq_src[7] = 1'b0;
        step("dis.hold");
        chk("dis.pend7", 32'(pending[7]), 32'd1);
        chk("dis.irq0", 32'(irq), 32'd0);
        en_we = 1'b1; en_wdata = 16'h0080;
        step("dis.wr");
        en_we = 1'b0;
        step("dis.grant");
        chk("dis.irq1", 32'(irq), 32'd1);
        chk("dis.id7", 32'(irq_id), 32'd7);
        irq_ack = 1'b1;
        step("dis.ack");
        irq_ack = 1'b0;

        // New edge on source 4 coincident with its ack
        async_reset("r36");
        en_we = 1'b1; en_wdata = 16'hFFFF;
        step("sw.en");
        en_we = 1'b0; irq_src[4] = 1'b1;
        step("sw.rise");
        irq_src[4] = 1'b0;
        step("sw.grant");
        chk("sw.id4", 32'(irq_id), 32'd4);
        irq_ack = 1'b1; irq_src[4] = 1'b1;
        step("sw.ackset");
        chk("sw.keep", 32'(pending[4]), 32'd1);
        chk("sw.gap", 32'(irq), 32'd0);
        irq_ack = 1'b0; irq_src[4] = 1'b0;
        step("sw.regrant");
        chk("sw.irq", 32'(irq), 32'd1);
        chk("sw.reid", 32'(irq_id), 32'd4);

        // Reset mid-grant, edge source held high through release, ack in idle
        irq_src[6] = 1'b1;
        async_reset("r37");
        step("r37.post");
        chk("r37.noedge", 32'(pending[6]), 32'd0);
        step("r37.hold");
        irq_ack = 1'b1;
        step("r37.ackidle");
        chk("r37.irq", 32'(irq), 32'd0);
        chk("r37.pend", 32'(pending), 32'd0);
        quiet_inputs();

        // Randomized traffic
        async_reset("rnd.init");
        for (int c = 0; c < 400; c++) begin
            irq_src  = 16'($urandom) & 16'($urandom);
            en_we    = ($urandom_range(0, 7) == 0);
            en_wdata = 16'($urandom);
            irq_ack  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) async_reset("rnd.rst");
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
